des_round_engine: RTL and testbench



---
 rtl/des_round_engine.sv | 165 ++++++++++++++++
 tb/tb_des_round_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_engine.sv
// Iterative DES datapath: initial permutation, sixteen Feistel rounds at one
// round per clock, final permutation. Round keys are read live from the key schedule.
module des_round_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        in_decrypt,
  input  logic [47:0] round_keys [0:15],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Tables use FIPS bit numbering: entry value n selects bit n, bit 1 being the MSB.
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box is 64 nibbles, row-major (row*16 + column), first entry in the top nibble.
  localparam logic [255:0] SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - IP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - FP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] v);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[5'(32 - E_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] v);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = v[5'(32 - P_T[5'(i)])];
    return o;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] g);
    logic [5:0]   idx;
    logic [7:0]   sh;
    logic [255:0] t;
    idx = {g[5], g[0], g[4:1]};
    // 4*(63-idx) without arithmetic: ~idx is 63-idx for a 6-bit value.
    sh  = {~idx, 2'b00};
    t   = SBOX[n] >> sh;
    return t[3:0];
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_perm(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = {s[27:0], sbox(3'(i), x[47:42])};
      x = x << 6;
    end
    return p_perm(s);
  endfunction

  state_t      state;
  logic [31:0] l_p0, r_p0;
  logic [3:0]  round_cnt;
  logic        mode;
  logic [47:0] k_sel;
  logic [31:0] l_new, r_new;

  always_comb begin
    k_sel = mode ? round_keys[4'd15 - round_cnt] : round_keys[round_cnt];
    l_new = r_p0;
    r_new = l_p0 ^ f_func(r_p0, k_sel);
  end

  // Round state register: IP result on accept, one Feistel round per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_block <= '0;
      l_p0      <= '0;
      r_p0      <= '0;
      round_cnt <= '0;
      mode      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            {l_p0, r_p0} <= ip_perm(in_block);
            mode         <= in_decrypt;
            round_cnt    <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          l_p0      <= l_new;
          r_p0      <= r_new;
          round_cnt <= round_cnt + 4'd1;
          if (round_cnt == 4'd15) begin
            // Halves are swapped after the last round before FP.
            out_block <= fp_perm({r_new, l_new});
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: FIPS vectors, backpressure, back-to-back, reset
// mid-run, busy-time input changes and random blocks against a bit-level DES model.
`timescale 1ns/1ps
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, out_block;
  logic [47:0] rk [0:15];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ov_rises = 0;
  int acc_q[$];
  logic [63:0] out_q[$];

  des_round_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_decrypt(in_decrypt), .round_keys(rk),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy));

  always #5 clk = ~clk;

  // Record accept edges (cycle number after the edge) and delivered results.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    if (out_valid && out_ready) out_q.push_back(out_block);
  end

  always @(posedge out_valid) ov_rises++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d required<50000", cyc);
    $fatal(1);
  end

  // ---------------- reference model (FIPS 46-3, bit 1 = MSB) ----------------
  int IP_T[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                  64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int FP_T[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                  37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int E_T[$]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                  16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int P_T[$]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int PC1_T[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SHIFTS[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  // One 16-nibble row per entry, S1 row 0 first.
  logic [63:0] SROW [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  // Select bits of a w-bit value (right-aligned in src) by 1-based MSB-first positions.
  function automatic logic [63:0] perm(input logic [63:0] src, input int w, input int t[$]);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < t.size(); i++) o = (o << 1) | ((src >> (w - t[i])) & 64'd1);
    return o;
  endfunction

  task automatic load_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    cd = 56'(perm(key, 64, PC1_T));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = (c << SHIFTS[i]) | (c >> (28 - SHIFTS[i]));
      d = (d << SHIFTS[i]) | (d >> (28 - SHIFTS[i]));
      rk[i] = 48'(perm({8'd0, c, d}, 56, PC2_T));
    end
  endtask

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    int g, row, col;
    e = 48'(perm({32'd0, r}, 32, E_T)) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      g = int'((e >> (42 - 6 * b)) & 48'h3F);
      row = (g / 32) * 2 + (g % 2);
      col = (g / 2) % 16;
      s = (s << 4) | 32'((SROW[b * 4 + row] >> (4 * (15 - col))) & 64'hF);
    end
    return 32'(perm({32'd0, s}, 32, P_T));
  endfunction

  function automatic logic [63:0] m_des(input logic [63:0] blk, input bit dec);
    logic [63:0] x;
    logic [31:0] l, r, t;
    x = perm(blk, 64, IP_T);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, dec ? rk[15 - i] : rk[i]);
      l = t;
    end
    return perm({r, l}, 64, FP_T);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
  endtask

  task automatic do_block(input logic [63:0] blk, input bit dec,
                          output logic [63:0] res, output int lat);
    int n, na;
    na = acc_q.size();
    @(negedge clk);
    in_valid = 1'b1; in_block = blk; in_decrypt = dec;
    n = 0;
    while (acc_q.size() == na && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b0; in_block = {$urandom, $urandom}; in_decrypt = ~dec;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    res = out_block;
    lat = (out_valid && acc_q.size() > na) ? cyc - acc_q[acc_q.size() - 1] : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (out_block !== 64'd0) begin n_bad++; $display("FAIL reset_out_block got=%h want=0", out_block); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset got in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_encrypt_fips();
    logic [63:0] res;
    int lat;
    load_key(64'h133457799BBCDFF1);
    out_ready = 1'b1;
    do_block(64'h0123456789ABCDEF, 1'b0, res, lat);
    n_cmp++; if (res !== 64'h85E813540F0AB405) begin n_bad++; $display("FAIL fips_encrypt got=%h want=85e813540f0ab405", res); end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL fips_encrypt_latency got=%0d want=16", lat); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL done_busy got=%b want=1", busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL after_handshake got out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    n_cmp++; if (out_block !== 64'h85E813540F0AB405) begin n_bad++; $display("FAIL out_block_retained got=%h want=85e813540f0ab405", out_block); end
  endtask

  task automatic test_decrypt_fips();
    logic [63:0] res;
    int lat;
    do_block(64'h85E813540F0AB405, 1'b1, res, lat);
    n_cmp++; if (res !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL fips_decrypt got=%h want=0123456789abcdef", res); end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL fips_decrypt_latency got=%0d want=16", lat); end
  endtask

  task automatic test_backpressure();
    logic [63:0] blk, res, exp;
    int lat, bad_v, bad_b, bad_r, hs, na;
    wait_idle();
    load_key({$urandom, $urandom});
    blk = {$urandom, $urandom};
    exp = m_des(blk, 1'b0);
    out_ready = 1'b0;
    do_block(blk, 1'b0, res, lat);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL bp_result got=%h want=%h", res, exp); end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL bp_latency got=%0d want=16", lat); end
    in_valid = 1'b1; in_block = {$urandom, $urandom};
    bad_v = 0; bad_b = 0; bad_r = 0;
    hs = out_q.size();
    na = acc_q.size();
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_v++;
      if (out_block !== exp) bad_b++;
      if (in_ready !== 1'b0) bad_r++;
    end
    n_cmp++; if (bad_v !== 0) begin n_bad++; $display("FAIL bp_out_valid_held bad_cycles=%0d want=0", bad_v); end
    n_cmp++; if (bad_b !== 0) begin n_bad++; $display("FAIL bp_out_block_held bad_cycles=%0d want=0", bad_b); end
    n_cmp++; if (bad_r !== 0) begin n_bad++; $display("FAIL bp_in_ready_low bad_cycles=%0d want=0", bad_r); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_q.size() !== hs + 1) begin n_bad++; $display("FAIL bp_handshakes got=%0d want=%0d", out_q.size() - hs, 1); end
    n_cmp++; if (acc_q.size() !== na) begin n_bad++; $display("FAIL bp_same_cycle_accept got=%0d want=0", acc_q.size() - na); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] got0, got1;
    int n, gap;
    wait_idle();
    load_key(64'h0E329232EA6D0D73);
    out_ready = 1'b1;
    acc_q.delete();
    out_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_block = 64'h8787878787878787; in_decrypt = 1'b0;
    @(negedge clk);
    in_block = 64'h0000000000000000; in_decrypt = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 60) begin @(negedge clk); n++; end
    in_valid = 1'b0; in_block = {$urandom, $urandom}; in_decrypt = 1'b0;
    n = 0;
    while (out_q.size() < 2 && n < 60) begin @(negedge clk); n++; end
    got0 = (out_q.size() > 0) ? out_q[0] : 'x;
    got1 = (out_q.size() > 1) ? out_q[1] : 'x;
    gap  = (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1;
    n_cmp++; if (out_q.size() !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d want=2", out_q.size()); end
    n_cmp++; if (got0 !== 64'h0) begin n_bad++; $display("FAIL b2b_first got=%h want=0000000000000000", got0); end
    n_cmp++; if (got1 !== 64'h8787878787878787) begin n_bad++; $display("FAIL b2b_second_decrypt got=%h want=8787878787878787", got1); end
    n_cmp++; if (gap !== 18) begin n_bad++; $display("FAIL b2b_accept_gap got=%0d want=18", gap); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] blk, res, exp;
    int lat, r0;
    wait_idle();
    load_key({$urandom, $urandom});
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_block = {$urandom, $urandom}; in_decrypt = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    r0 = ov_rises;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    n_cmp++; if (out_block !== 64'd0) begin n_bad++; $display("FAIL rst_mid_out_block got=%h want=0", out_block); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    n_cmp++; if (ov_rises !== r0) begin n_bad++; $display("FAIL rst_mid_spurious_valid got=%0d want=0", ov_rises - r0); end
    blk = {$urandom, $urandom};
    exp = m_des(blk, 1'b0);
    do_block(blk, 1'b0, res, lat);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rst_mid_next_block got=%h want=%h", res, exp); end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL rst_mid_next_latency got=%0d want=16", lat); end
  endtask

  task automatic test_busy_changes();
    logic [63:0] blk, exp, res;
    bit dec;
    int n, busy_bad;
    wait_idle();
    load_key({$urandom, $urandom});
    out_ready = 1'b1;
    blk = {$urandom, $urandom};
    dec = 1'($urandom);
    exp = m_des(blk, dec);
    @(negedge clk);
    in_valid = 1'b1; in_block = blk; in_decrypt = dec;
    @(negedge clk);
    n = 0; busy_bad = 0;
    while (!out_valid && n < 40) begin
      in_block = {$urandom, $urandom};
      in_decrypt = ~in_decrypt;
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
    res = out_block;
    in_valid = 1'b0;
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL busy_change_result got=%h want=%h", res, exp); end
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL busy_change_latency got=%0d want=16", n); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL busy_change_busy bad_cycles=%0d want=0", busy_bad); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] blk, exp, res, back;
    bit dec;
    int lat;
    for (int i = 0; i < 16; i++) begin
      wait_idle();
      if (i % 4 == 0) load_key({$urandom, $urandom});
      out_ready = 1'b1;
      blk = {$urandom, $urandom};
      dec = 1'($urandom);
      exp = m_des(blk, dec);
      do_block(blk, dec, res, lat);
      n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL random_%0d got=%h want=%h", i, res, exp); end
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL random_latency_%0d got=%0d want=16", i, lat); end
      do_block(res, ~dec, back, lat);
      n_cmp++; if (back !== blk) begin n_bad++; $display("FAIL roundtrip_%0d got=%h want=%h", i, back, blk); end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_fips();
    test_decrypt_fips();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_busy_changes();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
